// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_pkg
// Purpose : Shared types and reset constants for the mux_stream packet
//           multiplexer and its round-robin arbiter.
// Contents: mux_state_e      - two-state lock FSM encoding
//           RST_* constants  - reset values of the registered outputs
// Revision: 1.0 - initial release
// ============================================================================
package mux_pkg;

  typedef enum logic [0:0] {
    MUX_IDLE = 1'b0,
    MUX_LOCK = 1'b1
  } mux_state_e;

  localparam mux_state_e RST_STATE     = MUX_IDLE;
  localparam logic       RST_OUT_VALID = 1'b0;
  localparam logic       RST_OUT_LAST  = 1'b0;
  localparam logic       RST_BUSY      = 1'b0;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin arbiter. Priority starts at the channel
//           after ptr_i and wraps modulo N; the first requesting channel wins.
// Ports   : req_i        in  N     per-channel request
//           ptr_i        in  SELW  last granted channel
//           gnt_o        out N     one-hot grant
//           gnt_idx_o    out SELW  index of granted channel
//           gnt_valid_o  out 1     a grant was found
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [SELW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  // One spare bit: ptr (<= N-1) plus offset (<= N) stays below 2^(SELW+1).
  logic [SELW:0]   sum_w;
  logic [SELW-1:0] idx_w;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    sum_w       = '0;
    idx_w       = '0;
    for (int off = 1; off <= N; off++) begin
      sum_w = {1'b0, ptr_i} + (SELW+1)'(off);
      if (sum_w >= (SELW+1)'(N)) begin
        sum_w = sum_w - (SELW+1)'(N);
      end
      idx_w = sum_w[SELW-1:0];
      if (!gnt_valid_o && req_i[idx_w]) begin
        gnt_valid_o   = 1'b1;
        gnt_o[idx_w]  = 1'b1;
        gnt_idx_o     = idx_w;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_stream.sv
`default_nettype none
// ============================================================================
// Module  : mux_stream
// Purpose : N-channel, W-bit packet multiplexer. In IDLE it picks a channel
//           (from sel, or round-robin when enabled), locks onto it until the
//           beat carrying in_last is transferred, and forwards beats through
//           a single registered output stage with valid/ready handshaking.
// Config  : MUX_STREAM_RR_EN - when defined, adds the rr_mode port and the
//           round-robin arbiter with its pointer register. Undefined: grant
//           is always taken from sel.
// Ports   : clk        in  1     clock, rising edge
//           rst_n      in  1     asynchronous active-low reset
//           sel        in  SELW  requested channel (sampled only in IDLE)
//           rr_mode    in  1     1 = round-robin, 0 = sel (RR build only)
//           in_valid   in  N     per-channel beat valid
//           in_last    in  N     per-channel end-of-packet
//           in_data    in  N*W   channel i at [i*W +: W]
//           in_ready   out N     per-channel accept, at most one bit high
//           out_valid  out 1     output beat valid
//           out_last   out 1     output end-of-packet
//           out_data   out W     output beat
//           out_chan   out SELW  source channel of the output beat
//           out_ready  in  1     consumer accept
//           busy       out 1     high while locked onto a channel
// Revision: 1.0 - initial release
// ============================================================================
module mux_stream
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SELW-1:0] sel,
`ifdef MUX_STREAM_RR_EN
  input  logic            rr_mode,
`endif
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_last,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic            out_last,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  input  logic            out_ready,
  output logic            busy
);

  localparam int NPAD = 2**SELW;

  mux_state_e      state_q, state_d;
  logic [SELW-1:0] grant_q, grant_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q,  out_last_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_chan_q,  out_chan_d;
  logic            busy_q,      busy_d;

  // Per-channel data view, so the granted beat is a simple array read.
  logic [W-1:0] chan_data_w [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign chan_data_w[gi] = in_data[gi*W +: W];
  end

  // Valid padded up to a power of two so an out-of-range sel reads a
  // defined 0 instead of indexing past the vector.
  logic [NPAD-1:0] valid_pad_w;
  logic            sel_in_range_w;
  logic            fixed_ok_w;

  assign valid_pad_w    = NPAD'(in_valid);
  assign sel_in_range_w = ({1'b0, sel} < (SELW+1)'(N));
  assign fixed_ok_w     = sel_in_range_w && valid_pad_w[sel];

  // Candidate channel considered in IDLE.
  logic [SELW-1:0] cand_w;
  logic            cand_ok_w;

`ifdef MUX_STREAM_RR_EN
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    rr_gnt_w;
  logic [SELW-1:0] rr_idx_w;
  logic            rr_valid_w;

  rr_arbiter #(
    .N (N)
  ) u_rr_arbiter (
    .req_i       (in_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (rr_gnt_w),
    .gnt_idx_o   (rr_idx_w),
    .gnt_valid_o (rr_valid_w)
  );

  assign cand_w    = rr_mode ? rr_idx_w   : sel;
  assign cand_ok_w = rr_mode ? rr_valid_w : fixed_ok_w;

  // Pointer follows every grant; reset value N-1 gives channel 0 first turn.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == MUX_IDLE && cand_ok_w) begin
      rr_ptr_d = cand_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= SELW'(N-1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  logic unused_rr_w;
  assign unused_rr_w = ^rr_gnt_w;
`else
  assign cand_w    = sel;
  assign cand_ok_w = fixed_ok_w;
`endif

  // Lock FSM plus output-stage next state.
  logic lock_ready_w;
  logic take_w;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    in_ready    = '0;
    lock_ready_w = 1'b0;
    take_w       = 1'b0;

    // Consumer drains the stage; a new load below takes precedence.
    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      MUX_IDLE: begin
        if (cand_ok_w) begin
          grant_d = cand_w;
          state_d = MUX_LOCK;
        end
      end
      MUX_LOCK: begin
        // Accept when the single output slot is empty or being emptied.
        lock_ready_w      = !out_valid_q || out_ready;
        in_ready[grant_q] = lock_ready_w;
        take_w            = in_valid[grant_q] && lock_ready_w;
        if (take_w) begin
          out_valid_d = 1'b1;
          out_last_d  = in_last[grant_q];
          out_data_d  = chan_data_w[grant_q];
          out_chan_d  = grant_q;
          if (in_last[grant_q]) begin
            state_d = MUX_IDLE;
          end
        end
      end
      default: begin
        state_d = MUX_IDLE;
      end
    endcase

    busy_d = (state_d == MUX_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      grant_q     <= '0;
      out_valid_q <= RST_OUT_VALID;
      out_last_q  <= RST_OUT_LAST;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      busy_q      <= RST_BUSY;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign busy      = busy_q;

endmodule : mux_stream
`default_nettype wire

// File: tb/tb_mux_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_stream
// Purpose : Directed self-checking bench for mux_stream (N=4 and N=6).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        rr_mode;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_last;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;
  logic        busy;

  logic [2:0]  sel6;
  logic        rr_mode6;
  logic [5:0]  in_valid6;
  logic [5:0]  in_last6;
  logic [47:0] in_data6;
  logic [5:0]  in_ready6;
  logic        out_valid6;
  logic        out_last6;
  logic [7:0]  out_data6;
  logic [2:0]  out_chan6;
  logic        out_ready6;
  logic        busy6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_stream #(.N(4), .W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
`ifdef MUX_STREAM_RR_EN
    .rr_mode   (rr_mode),
`endif
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready),
    .busy      (busy)
  );

  mux_stream #(.N(6), .W(8)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel6),
`ifdef MUX_STREAM_RR_EN
    .rr_mode   (rr_mode6),
`endif
    .in_valid  (in_valid6),
    .in_last   (in_last6),
    .in_data   (in_data6),
    .in_ready  (in_ready6),
    .out_valid (out_valid6),
    .out_last  (out_last6),
    .out_data  (out_data6),
    .out_chan  (out_chan6),
    .out_ready (out_ready6),
    .busy      (busy6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d, input logic l);
    in_data[ch*8 +: 8] = d;
    in_last[ch]        = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel = '0; rr_mode = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    sel6 = '0; rr_mode6 = 1'b0; in_valid6 = '0; in_last6 = '0; in_data6 = '0; out_ready6 = 1'b1;
    tick(); tick();
    n_checks++;
    if ({out_valid, out_last, out_data, out_chan, in_ready, busy} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h c=%0d rdy=%b busy=%b, want all 0",
               out_valid, out_last, out_data, out_chan, in_ready, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    sel = 2'd2; in_valid = 4'b0100; set_ch(2, 8'hA1, 1'b0); out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: rdy=%b busy=%b, want 0000 0", in_ready, busy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 4'b0100 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_grant: busy=%b rdy=%b v=%b, want 1 0100 0", busy, in_ready, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_chan !== 2'd2 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL basic_beat1: v=%b d=%h c=%0d l=%b, want 1 a1 2 0", out_valid, out_data, out_chan, out_last);
    end
    set_ch(2, 8'hA2, 1'b0);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA2 || out_chan !== 2'd2 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL basic_beat2: v=%b d=%h c=%0d l=%b, want 1 a2 2 0", out_valid, out_data, out_chan, out_last);
    end
    set_ch(2, 8'hA3, 1'b1);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA3 || out_last !== 1'b1 || busy !== 1'b0 || in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL basic_beat3: v=%b d=%h l=%b busy=%b rdy=%b, want 1 a3 1 0 0000",
                         out_valid, out_data, out_last, busy, in_ready);
    end
    in_valid = '0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain: v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    sel = 2'd1; in_valid = 4'b0010; set_ch(1, 8'hB1, 1'b0); out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB1) begin
      n_fail++; $display("FAIL bp_first: v=%b d=%h, want 1 b1", out_valid, out_data);
    end
    set_ch(1, 8'hB2, 1'b0); out_ready = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL bp_ready_low: rdy=%b, want 0000", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hB1 || in_ready !== 4'b0000 || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d: v=%b d=%h rdy=%b busy=%b, want 1 b1 0000 1",
                           k, out_valid, out_data, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_ready_back: rdy=%b, want 0010", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2) begin
      n_fail++; $display("FAIL bp_b2: v=%b d=%h, want 1 b2", out_valid, out_data);
    end
    set_ch(1, 8'hB3, 1'b0);
    tick();
    n_checks++;
    if (out_data !== 8'hB3 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL bp_b3: d=%h l=%b, want b3 0", out_data, out_last);
    end
    set_ch(1, 8'hB4, 1'b1);
    tick();
    n_checks++;
    if (out_data !== 8'hB4 || out_last !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_b4: d=%h l=%b busy=%b, want b4 1 0", out_data, out_last, busy);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_sel_change();
    sel = 2'd1; in_valid = 4'b1010; set_ch(1, 8'hC1, 1'b0); set_ch(3, 8'hD1, 1'b1); out_ready = 1'b1;
    tick();
    sel = 2'd3;
    #1;
    n_checks++;
    if (in_ready !== 4'b0010 || busy !== 1'b1) begin
      n_fail++; $display("FAIL selchg_grant: rdy=%b busy=%b, want 0010 1", in_ready, busy);
    end
    tick();
    n_checks++;
    if (out_data !== 8'hC1 || out_chan !== 2'd1) begin
      n_fail++; $display("FAIL selchg_c1: d=%h c=%0d, want c1 1", out_data, out_chan);
    end
    set_ch(1, 8'hC2, 1'b1);
    tick();
    n_checks++;
    if (out_data !== 8'hC2 || out_chan !== 2'd1 || out_last !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL selchg_c2: d=%h c=%0d l=%b busy=%b, want c2 1 1 0", out_data, out_chan, out_last, busy);
    end
    in_valid = 4'b1000;
    tick();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 4'b1000 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL selchg_grant3: busy=%b rdy=%b v=%b, want 1 1000 0", busy, in_ready, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hD1 || out_chan !== 2'd3 || out_last !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL selchg_d1: v=%b d=%h c=%0d l=%b busy=%b, want 1 d1 3 1 0",
                         out_valid, out_data, out_chan, out_last, busy);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_bubble();
    sel = 2'd0; in_valid = 4'b0001; set_ch(0, 8'hE1, 1'b0); out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hE1) begin
      n_fail++; $display("FAIL bubble_e1: v=%b d=%h, want 1 e1", out_valid, out_data);
    end
    in_valid = '0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bubble_gap: v=%b busy=%b, want 0 1", out_valid, busy);
    end
    sel = 2'd2;
    tick();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL bubble_held: busy=%b rdy=%b, want 1 0001", busy, in_ready);
    end
    in_valid = 4'b0001; set_ch(0, 8'hE2, 1'b1);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hE2 || out_chan !== 2'd0 || out_last !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bubble_e2: v=%b d=%h c=%0d l=%b busy=%b, want 1 e2 0 1 0",
                         out_valid, out_data, out_chan, out_last, busy);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    sel = 2'd2; in_valid = 4'b0100; set_ch(2, 8'hF1, 1'b0); out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hF1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: v=%b d=%h busy=%b, want 1 f1 1", out_valid, out_data, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_last, out_data, out_chan, in_ready, busy} !== 17'd0) begin
      n_fail++;
      $display("FAIL rstmid_clear: v=%b l=%b d=%h c=%0d rdy=%b busy=%b, want all 0",
               out_valid, out_last, out_data, out_chan, in_ready, busy);
    end
    set_ch(2, 8'h61, 1'b1);
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_regrant: busy=%b v=%b, want 1 0", busy, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h61 || out_chan !== 2'd2 || out_last !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_new: v=%b d=%h c=%0d l=%b busy=%b, want 1 61 2 1 0",
                         out_valid, out_data, out_chan, out_last, busy);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_sel_range();
    sel6 = 3'd5; in_valid6 = 6'b011111; in_last6 = '0; out_ready6 = 1'b1;
    tick(); tick();
    n_checks++;
    if (busy6 !== 1'b0 || in_ready6 !== 6'b000000) begin
      n_fail++; $display("FAIL range_ch5_idle: busy=%b rdy=%b, want 0 000000", busy6, in_ready6);
    end
    sel6 = 3'd7;
    tick(); tick();
    n_checks++;
    if (busy6 !== 1'b0 || in_ready6 !== 6'b000000) begin
      n_fail++; $display("FAIL range_sel7: busy=%b rdy=%b, want 0 000000", busy6, in_ready6);
    end
    sel6 = 3'd4;
    tick();
    n_checks++;
    if (busy6 !== 1'b1 || in_ready6 !== 6'b010000) begin
      n_fail++; $display("FAIL range_sel4: busy=%b rdy=%b, want 1 010000", busy6, in_ready6);
    end
  endtask

`ifdef MUX_STREAM_RR_EN
  task automatic test_round_robin();
    logic [1:0] exp_ch;
    rst_n = 1'b0;
    in_valid = '0;
    tick();
    rst_n = 1'b1;
    rr_mode = 1'b1; sel = 2'd3; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_ch(c, 8'h10 + 8'(c), 1'b1);
    end
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ch = 2'(k % 4);
      tick();
      n_checks++;
      if (busy !== 1'b1 || in_ready !== (4'b0001 << exp_ch)) begin
        n_fail++; $display("FAIL rr_grant%0d: busy=%b rdy=%b, want 1 ch%0d", k, busy, in_ready, exp_ch);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== exp_ch || out_data !== (8'h10 + 8'(exp_ch)) || busy !== 1'b0) begin
        n_fail++; $display("FAIL rr_beat%0d: v=%b c=%0d d=%h busy=%b, want 1 %0d %h 0",
                           k, out_valid, out_chan, out_data, busy, exp_ch, 8'h10 + 8'(exp_ch));
      end
    end
    in_valid = '0;
    rr_mode  = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sel_change();
    test_bubble();
    test_reset_mid();
    test_sel_range();
`ifdef MUX_STREAM_RR_EN
    test_round_robin();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_stream
`default_nettype wire
